// File: rtl/bt_pkg.sv
// Shared constants and FSM state types for the Bluetooth move link (tx and rx sides).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bt_pkg;

  // Packet framing shared with the receive-side decoder
  localparam logic [7:0] BT_HDR     = 8'hAA;
  localparam int         BT_PKT_LEN = 5;

  // Packet sequencer: accept, present byte to core, wait for it, report completion
  typedef enum logic [1:0] {
    PKT_IDLE = 2'd0,
    PKT_LOAD = 2'd1,
    PKT_WAIT = 2'd2,
    PKT_DONE = 2'd3
  } pkt_state_e;

  // UART 8N1 byte serialiser
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_core.sv
// UART 8N1 byte serialiser on a 16x oversample tick (one tick = DVSR clk).
// Latency: tx goes low 1 clk after the START state is entered; byte_done is registered, 1 clk after STOP ends.
// Backpressure: start is only honoured while idle; callers must wait for byte_done.
module uart_tx_core
  import bt_pkg::*;
#(
  parameter int DVSR       = 27,
  parameter int DATA_WIDTH = 8,
  parameter int SB_TICK    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  tx,
  output logic                  byte_done,
  output logic                  idle
);

  localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  tx_state_e             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SW-1:0]         s_q, s_d;
  logic [NW-1:0]         n_q, n_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic                  tick;

  // Oversample tick: counter parked at 0 while idle so every byte starts phase-aligned
  assign tick = (state_q != TX_IDLE) && (cnt_q == CW'(DVSR - 1));

  // Tick counter next value
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (state_q == TX_IDLE || tick) cnt_d = '0;
  end

  // State, counters, shift register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // Next state: 16 ticks per start/data bit, SB_TICK ticks of stop
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    case (state_q)
      TX_IDLE: begin
        if (start) begin
          state_d = TX_START;
          s_d     = '0;
          b_d     = din;
        end
      end
      TX_START: begin
        if (tick) begin
          if (s_q == SW'(15)) begin
            state_d = TX_DATA;
            s_d     = '0;
            n_d     = '0;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      TX_DATA: begin
        if (tick) begin
          if (s_q == SW'(15)) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == NW'(DATA_WIDTH - 1)) state_d = TX_STOP;
            else                            n_d     = n_q + NW'(1);
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      TX_STOP: begin
        if (tick) begin
          if (s_q == SW'(SB_TICK - 1)) state_d = TX_IDLE;
          else                         s_d     = s_q + SW'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Output decode from the current state; registered above so tx is glitch-free
  always_comb begin
    tx_d   = 1'b1;
    done_d = 1'b0;
    case (state_q)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = b_q[0];
      TX_STOP:  done_d = tick && (s_q == SW'(SB_TICK - 1));
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx        = tx_q;
  assign byte_done = done_q;
  assign idle      = (state_q == TX_IDLE);

endmodule

// File: rtl/bt_move_tx.sv
// Frames one move (x, y, btn) as AA x y btn chk and sends it as UART 8N1 on tx.
// Latency: start bit 2 clk after accept; 2 idle clk between bytes; tx_done 1 clk before ready returns.
// Backpressure: send is accepted only while ready; sends while busy are dropped (no queue).
module bt_move_tx
  import bt_pkg::*;
#(
  parameter int DVSR       = 27,
  parameter int DATA_WIDTH = 8,
  parameter int SB_TICK    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  send,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] y,
  input  logic [DATA_WIDTH-1:0] btn,
  output logic                  ready,
  output logic                  busy,
  output logic                  tx,
  output logic                  tx_done
);

  localparam int IW = $clog2(BT_PKT_LEN);

  pkt_state_e            state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] x_q, x_d, y_q, y_d, btn_q, btn_d;
  logic [DATA_WIDTH-1:0] chk, byte_sel;
  logic                  core_start, core_done, core_idle;

  // Checksum is taken from the captured move, so input changes after accept cannot leak in
  assign chk = x_q ^ y_q ^ btn_q;

  // Byte presented to the serialiser for the current packet position
  always_comb begin
    byte_sel = DATA_WIDTH'(BT_HDR);
    case (idx_q)
      IW'(1):  byte_sel = x_q;
      IW'(2):  byte_sel = y_q;
      IW'(3):  byte_sel = btn_q;
      IW'(4):  byte_sel = chk;
      default: byte_sel = DATA_WIDTH'(BT_HDR);
    endcase
  end

  // Packet state, byte index and captured move
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PKT_IDLE;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      btn_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      btn_q   <= btn_d;
    end
  end

  // Packet sequencing: capture on accept, then one LOAD/WAIT pair per byte
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    btn_d   = btn_q;
    case (state_q)
      PKT_IDLE: begin
        if (send) begin
          state_d = PKT_LOAD;
          idx_d   = '0;
          x_d     = x;
          y_d     = y;
          btn_d   = btn;
        end
      end
      PKT_LOAD: begin
        if (core_idle) state_d = PKT_WAIT;
      end
      PKT_WAIT: begin
        if (core_done) begin
          if (idx_q == IW'(BT_PKT_LEN - 1)) begin
            state_d = PKT_DONE;
          end else begin
            state_d = PKT_LOAD;
            idx_d   = idx_q + IW'(1);
          end
        end
      end
      PKT_DONE: begin
        state_d = PKT_IDLE;
        idx_d   = '0;
      end
      default: state_d = PKT_IDLE;
    endcase
  end

  // Handshake and completion outputs decoded from the packet state
  always_comb begin
    ready      = (state_q == PKT_IDLE);
    busy       = (state_q != PKT_IDLE);
    tx_done    = (state_q == PKT_DONE);
    core_start = (state_q == PKT_LOAD) && core_idle;
  end

  uart_tx_core #(
    .DVSR       (DVSR),
    .DATA_WIDTH (DATA_WIDTH),
    .SB_TICK    (SB_TICK)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (core_start),
    .din       (byte_sel),
    .tx        (tx),
    .byte_done (core_done),
    .idle      (core_idle)
  );

endmodule

// File: tb/tb_bt_move_tx.sv
// Bench for bt_move_tx with DVSR=2: records the tx line per clock and decodes it as a UART receiver.
// Expected packets come from the framing rule AA x y btn (x^y^btn); timing from bit/byte arithmetic.
// Directed sequence: reset, single packet, busy ignore, input hold, back-to-back, mid-packet reset.
module tb_bt_move_tx;

  localparam int TMAX     = 20000;
  localparam int BIT_CLK  = 32;                  // 16 ticks * DVSR
  localparam int BYTE_CLK = (16 * 9 + 16) * 2;   // 320
  localparam int BSTEP    = BYTE_CLK + 2;        // byte start to byte start
  localparam int DONE_OFS = 2 + 5 * BYTE_CLK + 4 * 2;  // accept -> tx_done
  localparam int NEXT_ACC = DONE_OFS + 2;        // accept -> earliest next accept

  logic       clk = 1'b0;
  logic       rst;
  logic       send;
  logic [7:0] x, y, btn;
  logic       ready, busy, tx, tx_done;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   last_done = -1;
  int   exp_done = 0;
  logic trace [0:TMAX-1];

  bt_move_tx #(.DVSR(2), .DATA_WIDTH(8), .SB_TICK(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .send    (send),
    .x       (x),
    .y       (y),
    .btn     (btn),
    .ready   (ready),
    .busy    (busy),
    .tx      (tx),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Line recorder: trace[n] is the tx level during the clock after posedge n
  always @(negedge clk) if (cyc < TMAX) trace[cyc] <= tx;

  always @(negedge clk) begin
    if (tx_done === 1'b1) begin
      done_cnt  <= done_cnt + 1;
      last_done <= cyc;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [39:0] model_pkt(input logic [7:0] mx, input logic [7:0] my, input logic [7:0] mb);
    return {8'hAA, mx, my, mb, mx ^ my ^ mb};
  endfunction

  function automatic logic line_at(input int i);
    if (i < 0 || i >= TMAX) return 1'bx;
    return trace[i];
  endfunction

  function automatic int find_start(input int from, input int upto);
    for (int i = from; i <= upto; i++) begin
      if (i > 0 && i < TMAX && trace[i] === 1'b0 && trace[i-1] === 1'b1) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic accept(input logic [7:0] vx, input logic [7:0] vy, input logic [7:0] vb, output int a);
    a    = cyc + 1;
    send = 1'b1;
    x    = vx;
    y    = vy;
    btn  = vb;
    @(negedge clk);
    send = 1'b0;
  endtask

  // Decode five framed bytes expected to start at a+2+k*BSTEP and the tx_done pulse
  task automatic check_packet(input string tag, input int a, input logic [39:0] expp);
    int         pos, s, es;
    logic [7:0] d;
    wait_until(a + DONE_OFS + 10);
    pos = a;
    for (int k = 0; k < 5; k++) begin
      es = a + 2 + k * BSTEP;
      s  = find_start(pos, es + 64);
      chk($sformatf("%s_start%0d", tag, k), s, es);
      if (s < 0) s = es;
      d = 8'h00;
      for (int b = 0; b < 8; b++) d[b] = line_at(s + 16 + BIT_CLK * (b + 1));
      chk($sformatf("%s_byte%0d", tag, k), {24'h0, d}, {24'h0, expp[39-8*k -: 8]});
      chk($sformatf("%s_frame%0d", tag, k),
          {30'h0, line_at(s + 16), line_at(s + 16 + BIT_CLK * 9)}, 32'h1);
      pos = s + 16 + BIT_CLK * 9;
    end
    exp_done++;
    chk({tag, "_done_cyc"}, last_done, a + DONE_OFS);
    chk({tag, "_done_cnt"}, done_cnt, exp_done);
  endtask

  initial begin
    int         a, a1, t, rc;
    logic [7:0] rx, ry, rb;

    rst  = 1'b1;
    send = 1'b0;
    x    = 8'h00;
    y    = 8'h00;
    btn  = 8'h00;

    // Reset held for 3 clk
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_tx", {31'h0, tx}, 32'h1);
      chk("rst_ready", {31'h0, ready}, 32'h1);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_done", {31'h0, tx_done}, 32'h0);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_line_quiet", find_start(0, cyc - 1), -1);

    // Single directed packet AA 07 09 01 0F
    accept(8'h07, 8'h09, 8'h01, a);
    chk("single_busy", {31'h0, busy}, 32'h1);
    wait_until(a + DONE_OFS);
    chk("single_done_hi", {31'h0, tx_done}, 32'h1);
    chk("single_ready_lo", {31'h0, ready}, 32'h0);
    @(negedge clk);
    chk("single_ready_back", {31'h0, ready}, 32'h1);
    chk("single_done_lo", {31'h0, tx_done}, 32'h0);
    check_packet("single", a, model_pkt(8'h07, 8'h09, 8'h01));

    // Send pulsed while byte 2 is on the line is ignored
    rx = 8'($urandom); ry = 8'($urandom); rb = 8'($urandom);
    accept(rx, ry, rb, a);
    wait_until(a + 2 + 2 * BSTEP + 100);
    send = 1'b1;
    x    = 8'h33;
    @(negedge clk);
    send = 1'b0;
    check_packet("busy", a, model_pkt(rx, ry, rb));
    wait_until(a + NEXT_ACC + 800);
    chk("busy_no_second", find_start(a + NEXT_ACC, a + NEXT_ACC + 780), -1);
    chk("busy_ready", {31'h0, ready}, 32'h1);
    chk("busy_done_cnt", done_cnt, exp_done);

    // Inputs churn every clk after accept; captured values must be sent
    rx = 8'($urandom); ry = 8'($urandom); rb = 8'($urandom);
    accept(rx, ry, rb, a);
    while (cyc < a + NEXT_ACC) begin
      x   = 8'($urandom);
      y   = 8'($urandom);
      btn = 8'($urandom);
      @(negedge clk);
    end
    check_packet("hold", a, model_pkt(rx, ry, rb));

    // Back-to-back with send held high
    a1   = cyc + 1;
    send = 1'b1;
    x    = 8'h01; y = 8'h02; btn = 8'h03;
    @(negedge clk);
    x = 8'h04; y = 8'h05; btn = 8'h06;
    rc = 0;
    while (cyc < a1 + NEXT_ACC) begin
      if (ready === 1'b1) rc++;
      @(negedge clk);
    end
    send = 1'b0;
    chk("b2b_ready_clks", rc, 1);
    check_packet("b2b1", a1, 40'hAA_01_02_03_00);
    check_packet("b2b2", a1 + NEXT_ACC, 40'hAA_04_05_06_07);

    // Reset during data bit 3 of byte 3 (btn bit 3 forced low so tx is 0 there)
    rx = 8'($urandom); ry = 8'($urandom); rb = 8'($urandom) & 8'hF7;
    accept(rx, ry, rb, a);
    t = a + 2 + 3 * BSTEP + BIT_CLK * 4 + 10;
    wait_until(t);
    chk("mid_pre_tx", {31'h0, tx}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx", {31'h0, tx}, 32'h1);
    chk("mid_rst_ready", {31'h0, ready}, 32'h1);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // rst and send together: reset wins
    rst  = 1'b1;
    send = 1'b1;
    x    = 8'($urandom);
    @(negedge clk);
    rst  = 1'b0;
    send = 1'b0;
    @(negedge clk);
    chk("rst_send_ready", {31'h0, ready}, 32'h1);
    repeat (600) @(negedge clk);
    chk("mid_line_quiet", find_start(t, cyc - 1), -1);
    chk("mid_done_cnt", done_cnt, exp_done);

    rx = 8'($urandom); ry = 8'($urandom); rb = 8'($urandom);
    accept(rx, ry, rb, a);
    check_packet("post_rst", a, model_pkt(rx, ry, rb));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
